// File: rtl/serial_wb_pkg.sv
// Shared definitions for the serial-to-bus bridge:
// command codes, FSM states and the command decoder.
package serial_wb_pkg;

  localparam logic [7:0] CMD_WR_INC = 8'h57;
  localparam logic [7:0] CMD_WR_FIX = 8'h77;
  localparam logic [7:0] CMD_RD_INC = 8'h52;
  localparam logic [7:0] CMD_RD_FIX = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_WDATA,
    ST_RSTROBE,
    ST_RSEND
  } state_t;

  typedef struct packed {
    logic valid;
    logic rd;
    logic inc;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c = '0;
    unique case (1'b1)
      (b == CMD_WR_INC): c = '{valid: 1'b1, rd: 1'b0, inc: 1'b1};
      (b == CMD_WR_FIX): c = '{valid: 1'b1, rd: 1'b0, inc: 1'b0};
      (b == CMD_RD_INC): c = '{valid: 1'b1, rd: 1'b1, inc: 1'b1};
      (b == CMD_RD_FIX): c = '{valid: 1'b1, rd: 1'b1, inc: 1'b0};
      default:           c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_wb_timer.sv
// Inter-byte idle timer: counts enabled cycles,
// flags the cycle in which the idle limit is reached.
module serial_wb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TIMER_W        = 20
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST =
    TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt;

  // A clear (new byte) always beats expiry.
  assign expired = en && !clr && (cnt == LAST);

  // Idle counter; restarts on clear or once expired.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr || expired) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_wb_master.sv
// Byte-stream command parser driving a simple
// strobe-based register bus, with read responses.
module serial_wb_master
  import serial_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TIMER_W        = 20
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] address_o,
  output logic [7:0] data_o,
  output logic       writestrobe_o,
  output logic       readstrobe_o,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       timeout_o
);

  state_t     state;
  logic       inc_q;
  logic       rd_q;
  logic [8:0] count_q;
  cmd_t       cmd;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_exp;

  assign cmd     = decode_cmd(rx_data_i);
  assign busy_o  = (state != ST_IDLE);
  assign tmr_clr = rx_valid_i || (state == ST_IDLE);
  assign tmr_en  = (state == ST_ADDR)
                || (state == ST_COUNT)
                || (state == ST_WDATA);

  serial_wb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMER_W        (TIMER_W)
  ) u_timer (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // Command FSM with registered bus and tx outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= ST_IDLE;
      inc_q         <= 1'b0;
      rd_q          <= 1'b0;
      count_q       <= '0;
      address_o     <= '0;
      data_o        <= '0;
      tx_data_o     <= '0;
      tx_valid_o    <= 1'b0;
      writestrobe_o <= 1'b0;
      readstrobe_o  <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      writestrobe_o <= 1'b0;
      readstrobe_o  <= 1'b0;
      timeout_o     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx_valid_i && cmd.valid) begin
            inc_q <= cmd.inc;
            rd_q  <= cmd.rd;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (rx_valid_i) begin
            address_o <= rx_data_i;
            state     <= ST_COUNT;
          end else if (tmr_exp) begin
            state     <= ST_IDLE;
            timeout_o <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (rx_valid_i) begin
            count_q <= {(rx_data_i == 8'h00), rx_data_i};
            if (rd_q) begin
              state        <= ST_RSTROBE;
              readstrobe_o <= 1'b1;
            end else begin
              state <= ST_WDATA;
            end
          end else if (tmr_exp) begin
            state     <= ST_IDLE;
            timeout_o <= 1'b1;
          end
        end
        ST_WDATA: begin
          // Retire the strobe issued last cycle.
          if (writestrobe_o) begin
            count_q <= count_q - 9'd1;
            if (inc_q) address_o <= address_o + 8'd1;
            if (count_q == 9'd1) state <= ST_IDLE;
          end
          if (rx_valid_i
              && !(writestrobe_o && count_q == 9'd1)) begin
            data_o        <= rx_data_i;
            writestrobe_o <= 1'b1;
          end else if (tmr_exp) begin
            state     <= ST_IDLE;
            timeout_o <= 1'b1;
          end
        end
        ST_RSTROBE: begin
          tx_data_o  <= data_i;
          tx_valid_o <= 1'b1;
          state      <= ST_RSEND;
        end
        ST_RSEND: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            count_q    <= count_q - 9'd1;
            if (inc_q) address_o <= address_o + 8'd1;
            if (count_q == 9'd1) begin
              state <= ST_IDLE;
            end else begin
              state        <= ST_RSTROBE;
              readstrobe_o <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
